// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: steps one external full_adder cell WIDTH times, LSB first,
// keeping the carry in a register and presenting sum/carry/overflow over valid/ready.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout_out,
    output logic             ovf_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  sum_reg, sum_next;
    logic              carry_reg, carry_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic              cout_reg, cout_next;
    logic              ovf_reg, ovf_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            sum_reg    <= '0;
            carry_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            sum_reg    <= sum_next;
            carry_reg  <= carry_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            cout_reg   <= cout_next;
            ovf_reg    <= ovf_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        sum_next    = sum_reg;
        carry_next  = carry_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        cout_next   = cout_reg;
        ovf_next    = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_next     = op_a;
                    b_next     = op_b;
                    carry_next = cin_in;
                    cnt_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                sum_next   = {fa_sum, sum_reg[WIDTH-1:1]};
                carry_next = fa_cout;
                a_next     = a_reg >> 1;
                b_next     = b_reg >> 1;
                cnt_next   = cnt_reg + 1'b1;
                // Outputs are captured only on the final bit so no partial sum is ever visible.
                if (cnt_reg == LAST_BIT) begin
                    result_next = {fa_sum, sum_reg[WIDTH-1:1]};
                    cout_next   = fa_cout;
                    ovf_next    = carry_reg ^ fa_cout;
                    cnt_next    = '0;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign cout_out  = cout_reg;
    assign ovf_out   = ovf_reg;

    assign fa_a   = (state_reg == RUN) && a_reg[0];
    assign fa_b   = (state_reg == RUN) && b_reg[0];
    assign fa_cin = (state_reg == RUN) && carry_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 and WIDTH=2 instances, each wired to a
// behavioural full_adder cell, checked against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W  = 8;
    localparam int W2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, cin_in, out_valid, out_ready;
    logic [W-1:0] op_a, op_b, result;
    logic         cout_out, ovf_out, fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    logic          in_valid2, in_ready2, cin_in2, out_valid2, out_ready2;
    logic [W2-1:0] op_a2, op_b2, result2;
    logic          cout_out2, ovf_out2, fa_a2, fa_b2, fa_cin2, fa_sum2, fa_cout2;

    int tests_run    = 0;
    int tests_failed = 0;
    logic fa_trace[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin_in(cin_in), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .cout_out(cout_out), .ovf_out(ovf_out),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
    );

    serial_add_ctrl #(.WIDTH(W2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .op_a(op_a2), .op_b(op_b2), .cin_in(cin_in2), .out_valid(out_valid2),
        .out_ready(out_ready2), .result(result2), .cout_out(cout_out2), .ovf_out(ovf_out2),
        .fa_a(fa_a2), .fa_b(fa_b2), .fa_cin(fa_cin2), .fa_sum(fa_sum2), .fa_cout(fa_cout2)
    );

    // Behavioural full_adder cells.
    assign fa_sum   = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout  = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));
    assign fa_sum2  = fa_a2 ^ fa_b2 ^ fa_cin2;
    assign fa_cout2 = (fa_a2 & fa_b2) | (fa_cin2 & (fa_a2 ^ fa_b2));

    // Returns {ovf, cout, sum}: plain integer addition; overflow when same-sign operands give a different-sign sum.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a, input logic [63:0] b, input logic c);
        logic [64:0] s;
        logic [63:0] mask;
        logic        v;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        s = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
        v = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {v, s[w], s[63:0] & mask};
    endfunction

    // One operation on the 8-bit instance; starts and ends at a falling edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] r, output logic co, output logic ov,
                          output int lat, output logic acc);
        op_a = a; op_b = b; cin_in = c; in_valid = 1'b1; out_ready = 1'b0;
        acc = in_ready;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        fa_trace.delete();
        lat = 0;
        while (!out_valid && lat < 100) begin
            fa_trace.push_back(fa_a);
            @(posedge clk); @(negedge clk);
            lat++;
        end
        r = result; co = cout_out; ov = ovf_out;
        $display("[TB] w8 op %02h + %02h + %0d -> %02h cout=%0d ovf=%0d latency=%0d", a, b, c, r, co, ov, lat);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic op_w2(input logic [W2-1:0] a, input logic [W2-1:0] b, input logic c,
                         output logic [W2-1:0] r, output logic co, output logic ov, output int lat);
        op_a2 = a; op_b2 = b; cin_in2 = c; in_valid2 = 1'b1; out_ready2 = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 100) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        r = result2; co = cout_out2; ov = ovf_out2;
        $display("[TB] w2 op %0d + %0d + %0d -> %0d cout=%0d ovf=%0d latency=%0d", a, b, c, r, co, ov, lat);
        out_ready2 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; op_a = '0; op_b = '0; cin_in = 0; out_ready = 0;
        in_valid2 = 0; op_a2 = '0; op_b2 = '0; cin_in2 = 0; out_ready2 = 0;
        @(negedge clk);
        tests_run++;
        if ({in_ready, out_valid, result, cout_out, ovf_out, fa_a, fa_b, fa_cin} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got in_ready=%b out_valid=%b result=%h cout=%b ovf=%b fa=%b%b%b, need all 0",
                     in_ready, out_valid, result, cout_out, ovf_out, fa_a, fa_b, fa_cin);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, need 1 0", in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] va[4] = '{8'h5A, 8'hFF, 8'hFF, 8'h80};
        logic [W-1:0] vb[4] = '{8'h3C, 8'h01, 8'h00, 8'h80};
        logic         vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W+1:0] vexp[4] = '{{1'b1, 1'b0, 8'h96}, {1'b0, 1'b1, 8'h00},
                                  {1'b0, 1'b1, 8'h00}, {1'b1, 1'b1, 8'h00}};
        logic [W-1:0] r, pat;
        logic co, ov, acc;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], r, co, ov, lat, acc);
            tests_run++;
            if ({acc, lat} !== {1'b1, W}) begin
                tests_failed++;
                $display("FAIL directed_latency[%0d]: got accepted=%b latency=%0d, need 1 %0d", i, acc, lat, W);
            end
            tests_run++;
            if ({ov, co, r} !== vexp[i]) begin
                tests_failed++;
                $display("FAIL directed_result[%0d]: got ovf=%b cout=%b result=%h, need %b %b %h",
                         i, ov, co, r, vexp[i][W+1], vexp[i][W], vexp[i][W-1:0]);
            end
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL directed_handoff[%0d]: got out_valid=%b in_ready=%b, need 0 1", i, out_valid, in_ready);
            end
            if (i == 0) begin
                pat = va[0];
                tests_run++;
                if (fa_trace.size() != W) begin
                    tests_failed++;
                    $display("FAIL fa_a_trace_len: got %0d, need %0d", fa_trace.size(), W);
                end else begin
                    for (int k = 0; k < W; k++) begin
                        if (fa_trace[k] !== pat[k]) begin
                            tests_failed++;
                            $display("FAIL fa_a_trace[%0d]: got %b, need %b", k, fa_trace[k], pat[k]);
                            break;
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, r;
        logic c, co, ov, acc;
        logic [65:0] e;
        int lat;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            e = ref_add(W, {56'd0, a}, {56'd0, b}, c);
            run_op(a, b, c, r, co, ov, lat, acc);
            tests_run++;
            if ({acc, lat, ov, co, r} !== {1'b1, W, e[65], e[64], e[W-1:0]}) begin
                tests_failed++;
                $display("FAIL random[%0d] %h+%h+%0d: got acc=%b lat=%0d ovf=%b cout=%b result=%h, need 1 %0d %b %b %h",
                         i, a, b, c, acc, lat, ov, co, r, W, e[65], e[64], e[W-1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a, b, r;
        logic co, ov, acc;
        logic [65:0] e;
        int n, lat;
        a = 8'h7F; b = 8'h01;
        e = ref_add(W, {56'd0, a}, {56'd0, b}, 1'b0);
        op_a = a; op_b = b; cin_in = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        $display("[TB] w8 backpressure op %02h + %02h -> %02h cout=%0d ovf=%0d", a, b, result, cout_out, ovf_out);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({out_valid, in_ready, ovf_out, cout_out, result} !== {1'b1, 1'b0, e[65], e[64], e[W-1:0]}) begin
                tests_failed++;
                $display("FAIL backpressure[%0d]: got valid=%b ready=%b ovf=%b cout=%b result=%h, need 1 0 %b %b %h",
                         i, out_valid, in_ready, ovf_out, cout_out, result, e[65], e[64], e[W-1:0]);
            end
            in_valid = (i == 2);
            op_a = 8'hC3; op_b = 8'h99; cin_in = 1'b1;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL backpressure_release: got out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
        end
        a = 8'h21; b = 8'h42;
        e = ref_add(W, {56'd0, a}, {56'd0, b}, 1'b0);
        run_op(a, b, 1'b0, r, co, ov, lat, acc);
        tests_run++;
        if ({acc, lat, ov, co, r} !== {1'b1, W, e[65], e[64], e[W-1:0]}) begin
            tests_failed++;
            $display("FAIL backpressure_next_op: got acc=%b lat=%0d ovf=%b cout=%b result=%h, need 1 %0d %b %b %h",
                     acc, lat, ov, co, r, W, e[65], e[64], e[W-1:0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [65:0] expq[$];
        logic [65:0] e;
        logic [W-1:0] a, b;
        logic c;
        int accepts = 0, got = 0, last_acc = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 120 && got < 5; cyc++) begin
            if (out_valid) begin
                tests_run++;
                if (expq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_spurious: out_valid with no operation pending at cycle %0d", cyc);
                end else begin
                    e = expq.pop_front();
                    $display("[TB] w8 b2b result %02h cout=%0d ovf=%0d", result, cout_out, ovf_out);
                    if ({ovf_out, cout_out, result} !== {e[65], e[64], e[W-1:0]}) begin
                        tests_failed++;
                        $display("FAIL b2b_result[%0d]: got ovf=%b cout=%b result=%h, need %b %b %h",
                                 got, ovf_out, cout_out, result, e[65], e[64], e[W-1:0]);
                    end
                end
                got++;
            end
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            op_a = a; op_b = b; cin_in = c;
            in_valid = (accepts < 5);
            if (in_valid && in_ready) begin
                expq.push_back(ref_add(W, {56'd0, a}, {56'd0, b}, c));
                if (last_acc >= 0) begin
                    tests_run++;
                    if (cyc - last_acc != W + 2) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing: got %0d cycles, need %0d", cyc - last_acc, W + 2);
                    end
                end
                last_acc = cyc;
                accepts++;
            end
            @(posedge clk); @(negedge clk);
        end
        tests_run++;
        if (got != 5) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d results, need 5", got);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r;
        logic co, ov, acc;
        int lat;
        run_op(8'h12, 8'h34, 1'b0, r, co, ov, lat, acc);
        tests_run++;
        if (result !== 8'h46) begin
            tests_failed++;
            $display("FAIL pre_reset_hold: got result=%h, need 46", result);
        end
        op_a = 8'hFF; op_b = 8'hFF; cin_in = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if ({fa_a, fa_b, fa_cin} !== 3'b111) begin
            tests_failed++;
            $display("FAIL mid_run_cell_drive: got fa=%b%b%b, need 111", fa_a, fa_b, fa_cin);
        end
        rst = 1'b1;
        #1;
        $display("[TB] w8 reset asserted mid-run");
        tests_run++;
        if ({in_ready, out_valid, result, cout_out, ovf_out, fa_a, fa_b, fa_cin} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got in_ready=%b out_valid=%b result=%h cout=%b ovf=%b fa=%b%b%b, need all 0",
                     in_ready, out_valid, result, cout_out, ovf_out, fa_a, fa_b, fa_cin);
        end
        @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(8'h01, 8'h01, 1'b0, r, co, ov, lat, acc);
        tests_run++;
        if ({acc, lat, ov, co, r} !== {1'b1, W, 1'b0, 1'b0, 8'h02}) begin
            tests_failed++;
            $display("FAIL post_reset_op: got acc=%b lat=%0d ovf=%b cout=%b result=%h, need 1 %0d 0 0 02",
                     acc, lat, ov, co, r, W);
        end
    endtask

    task automatic test_width2();
        logic [W2-1:0] r, a, b;
        logic co, ov, c;
        logic [65:0] e;
        int lat;
        op_w2(2'b11, 2'b01, 1'b1, r, co, ov, lat);
        tests_run++;
        if ({lat, ov, co, r} !== {W2, 1'b0, 1'b1, 2'b01}) begin
            tests_failed++;
            $display("FAIL w2_directed: got lat=%0d ovf=%b cout=%b result=%b, need 2 0 1 01", lat, ov, co, r);
        end
        for (int i = 0; i < 32; i++) begin
            a = i[1:0]; b = i[3:2]; c = i[4];
            e = ref_add(W2, {62'd0, a}, {62'd0, b}, c);
            op_w2(a, b, c, r, co, ov, lat);
            tests_run++;
            if ({lat, ov, co, r} !== {W2, e[65], e[64], e[W2-1:0]}) begin
                tests_failed++;
                $display("FAIL w2_sweep %0d+%0d+%0d: got lat=%0d ovf=%b cout=%b result=%b, need %0d %b %b %b",
                         a, b, c, lat, ov, co, r, W2, e[65], e[64], e[W2-1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_width2();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition sequencer that time-multiplexes one external single-bit `full_adder` cell to add two WIDTH-bit operands, LSB first, one bit per clock. It accepts operand pairs over a valid/ready input handshake, steps the adder cell WIDTH times while propagating the carry in a register, and presents the WIDTH-bit sum, carry-out and signed overflow over a valid/ready output handshake. It sits between an operand producer and a result consumer where area matters more than throughput.

## Interface
- `WIDTH`, 8, operand/result width in bits; legal range 2..64.
- `clk` in 1, single clock; all state updates on the rising edge.
- `rst` in 1, asynchronous, active-high reset.
- `in_valid` in 1, operand pair and `cin_in` are valid.
- `in_ready` out 1, block can accept operands.
- `op_a` in WIDTH, first operand.
- `op_b` in WIDTH, second operand.
- `cin_in` in 1, initial carry-in for bit 0.
- `out_valid` out 1, result fields are valid.
- `out_ready` in 1, consumer accepts the result.
- `result` out WIDTH, sum bits.
- `cout_out` out 1, carry out of bit WIDTH-1.
- `ovf_out` out 1, two's-complement overflow (carry into MSB XOR carry out of MSB).
- `fa_a`, `fa_b`, `fa_cin` out 1 each, drive the shared full_adder cell.
- `fa_sum`, `fa_cout` in 1 each, combinational returns from the cell.

## Operation
- States: IDLE, RUN, DONE (two-bit encoded).
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch `op_a`/`op_b` into shift registers A/B, load carry register with `cin_in`, clear bit counter, go to RUN.
- RUN: `fa_a`=A[0], `fa_b`=B[0], `fa_cin`=carry. Each cycle, shift `fa_sum` into the MSB of the result shift register (shift right), update carry with `fa_cout`, shift A/B right, and increment the counter. When counter = WIDTH-1 in the same cycle, also capture `ovf_out` = carry XOR `fa_cout` and move to DONE.
- DONE: `out_valid`=1. `result`, `cout_out` (= carry register) and `ovf_out` are held stable. On `out_ready`, return to IDLE.
- `in_ready` is combinational: (state = IDLE) AND NOT `rst`. `in_valid` outside IDLE is ignored, and operands are not re-sampled.
- `fa_a`, `fa_b`, `fa_cin` are driven to 0 in IDLE and DONE.
- Counter width is clog2(WIDTH). Result is modulo 2^WIDTH, with the carry reported separately.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge): state IDLE, `in_ready`=0 while `rst` is high, `out_valid`=0, `result`=0, `cout_out`=0, `ovf_out`=0, `fa_*` outputs 0, counter 0, carry 0.
- Latency: accept at edge k, then RUN covers cycles k+1..k+WIDTH, and `out_valid` rises after edge k+WIDTH.
- Throughput: at most one operation per WIDTH+2 cycles (one IDLE cycle is required between operations).
- Backpressure: `out_valid` stays high and the outputs stay constant while `out_ready` is low, for any duration.
- If `out_ready` is already high on entry to DONE, the result is transferred in exactly one cycle.
- Reset mid-RUN or mid-DONE aborts the operation immediately. No partial result is ever presented, and the first post-reset operation is correct.
- The `fa_sum`/`fa_cout` path is combinational from the `fa_*` outputs, so the cell must settle within one clock period.

## Test plan
- 0x5A + 0x3C, `cin_in`=0, WIDTH=8 -> `result`=0x96, `cout_out`=0, `ovf_out`=1. `out_valid` rises exactly 8 cycles after the accept edge. `fa_a` sequence LSB-first is 0,1,0,1,1,0,1,0.
- 0xFF + 0x01, `cin_in`=0 -> 0x00, cout 1, ovf 0. Then 0xFF + 0x00, `cin_in`=1 -> 0x00, cout 1, ovf 0. Then 0x80 + 0x80 -> 0x00, cout 1, ovf 1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `out_valid`, `result` and flags are unchanged, `in_ready`=0, and a pulse on `in_valid` is ignored. On release, the next op is accepted only from IDLE.
- `in_valid` held high continuously with changing operands -> each result matches the operands sampled at its own accept edge. Spacing between accepts is 10 cycles for WIDTH=8.
- Assert `rst` after 3 RUN cycles -> all outputs are at their reset values asynchronously. After release, 0x01 + 0x01 -> 0x02, cout 0, ovf 0.
- WIDTH=2 build: 2'b11 + 2'b01, cin 1 -> 2'b01, cout 1, ovf 0, with latency 2 cycles.
